// File: rtl/multi_blink.sv
// Multi-channel LED pattern generator: shared tick prescaler, per-channel OFF/ON/BLINK/PWM.
// Optional feature macro: MULTI_BLINK_PWM_EN (duty registers and PWM comparators).
module multi_blink #(
  parameter  int NUM_CH    = 12,
  parameter  int PRESC_DIV = 50000,
  parameter  int PER_W     = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PS_W      = $clog2(PRESC_DIV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [PER_W-1:0]  cfg_duty,
  output logic              tick,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] led_n
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [PS_W-1:0]  presc_q;
  mode_e            mode_q  [NUM_CH];
  logic [PER_W-1:0] per_q   [NUM_CH];
  logic [PER_W-1:0] cnt_q   [NUM_CH];
  logic [NUM_CH-1:0] blink_q;

`ifdef MULTI_BLINK_PWM_EN
  logic [PER_W-1:0] duty_q  [NUM_CH];
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif

  logic              ch_valid;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] lit;

  always_comb begin
    ch_valid = (int'(cfg_ch) < NUM_CH);
    wr_sel   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_we && ch_valid && (cfg_ch == CH_W'(i));
    end
  end

  // Without the PWM build, mode 3 falls back to the blink bit.
  always_comb begin
    lit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      case (mode_q[i])
        MODE_OFF:   lit[i] = 1'b0;
        MODE_ON:    lit[i] = 1'b1;
        MODE_BLINK: lit[i] = blink_q[i];
`ifdef MULTI_BLINK_PWM_EN
        MODE_PWM:   lit[i] = (cnt_q[i] < duty_q[i]);
`else
        MODE_PWM:   lit[i] = blink_q[i];
`endif
        default:    lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick    <= 1'b0;
      cfg_err <= 1'b0;
      led_n   <= '1;
      blink_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= MODE_OFF;
        per_q[i]  <= '0;
        cnt_q[i]  <= '0;
`ifdef MULTI_BLINK_PWM_EN
        duty_q[i] <= '0;
`endif
      end
    end else begin
      if (presc_q == PS_W'(PRESC_DIV - 1)) begin
        presc_q <= '0;
        tick    <= 1'b1;
      end else begin
        presc_q <= presc_q + PS_W'(1);
        tick    <= 1'b0;
      end

      cfg_err <= cfg_we && !ch_valid;
      led_n   <= ~lit;

      // A write on a tick edge takes precedence over the phase advance.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) begin
          mode_q[i]  <= mode_e'(cfg_mode);
          per_q[i]   <= cfg_period;
          cnt_q[i]   <= '0;
          blink_q[i] <= 1'b0;
`ifdef MULTI_BLINK_PWM_EN
          duty_q[i]  <= cfg_duty;
`endif
        end else if (tick) begin
          if (cnt_q[i] == per_q[i]) begin
            cnt_q[i]   <= '0;
            blink_q[i] <= ~blink_q[i];
          end else begin
            cnt_q[i]   <= cnt_q[i] + PER_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_blink.sv
// Scoreboard bench for multi_blink (NUM_CH=4, PRESC_DIV=4, PER_W=4) plus a NUM_CH=3 instance for invalid writes.
module tb_multi_blink;

  localparam int NCH = 4;
  localparam int PD  = 4;
  localparam int PW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [PW-1:0] cfg_period = '0;
  logic [PW-1:0] cfg_duty = '0;
  logic          tick, cfg_err;
  logic [NCH-1:0] led_n;
  logic          tick3, err3;
  logic [2:0]    led_n3;

  always #5 clk = ~clk;

  multi_blink #(.NUM_CH(NCH), .PRESC_DIV(PD), .PER_W(PW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .tick(tick), .cfg_err(cfg_err), .led_n(led_n)
  );

  multi_blink #(.NUM_CH(3), .PRESC_DIV(PD), .PER_W(PW)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .tick(tick3), .cfg_err(err3), .led_n(led_n3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [NCH-1:0] led;
    logic           tck;
    logic           err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: state after each edge, outputs registered from pre-edge state.
  int unsigned   m_presc;
  logic          m_tick, m_err;
  logic [NCH-1:0] m_led;
  logic [1:0]    m_mode [NCH];
  logic [PW-1:0] m_per  [NCH];
  logic [PW-1:0] m_duty [NCH];
  logic [PW-1:0] m_cnt  [NCH];
  logic          m_b    [NCH];

  function automatic logic m_lit(input int c);
    case (m_mode[c])
      2'd0: return 1'b0;
      2'd1: return 1'b1;
      2'd2: return m_b[c];
`ifdef MULTI_BLINK_PWM_EN
      default: return m_cnt[c] < m_duty[c];
`else
      default: return m_b[c];
`endif
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_presc = 0;
      m_tick  = 1'b0;
      m_err   = 1'b0;
      m_led   = '1;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 2'd0; m_per[c] = '0; m_duty[c] = '0; m_cnt[c] = '0; m_b[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) m_led[c] = !m_lit(c);
      m_err = cfg_we && (int'(cfg_ch) >= NCH);
      for (int c = 0; c < NCH; c++) begin
        if (cfg_we && int'(cfg_ch) == c) begin
          m_mode[c] = cfg_mode; m_per[c] = cfg_period; m_duty[c] = cfg_duty;
          m_cnt[c] = '0; m_b[c] = 1'b0;
        end else if (m_tick) begin
          if (m_cnt[c] == m_per[c]) begin
            m_cnt[c] = '0;
            m_b[c]   = !m_b[c];
          end else begin
            m_cnt[c] = m_cnt[c] + 1'b1;
          end
        end
      end
      m_tick  = (m_presc == PD - 1);
      m_presc = (m_presc + 1) % PD;
    end
    e.led = m_led; e.tck = m_tick; e.err = m_err;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led_n", 64'(led_n), 64'(e.led));
      check("tick", 64'(tick), 64'(e.tck));
      check("cfg_err", 64'(cfg_err), 64'(e.err));
    end
  end

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode,
                    input logic [PW-1:0] per, input logic [PW-1:0] duty);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_duty = duty;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Measures one full low run followed by the high run on led_n[k], in clocks.
  task automatic pulse(input int k, output int lo, output int hi);
    int g = 0;
    while (led_n[k] !== 1'b1 && g < 200) begin @(negedge clk); g++; end
    while (led_n[k] !== 1'b0 && g < 200) begin @(negedge clk); g++; end
    lo = 0;
    while (led_n[k] === 1'b0 && lo < 200) begin lo++; @(negedge clk); end
    hi = 0;
    while (led_n[k] === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
  endtask

  task automatic hold(input int k, input logic lvl, input string tag);
    int bad = 0;
    repeat (2) @(negedge clk);
    repeat (20) begin
      if (led_n[k] !== lvl) bad++;
      @(negedge clk);
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int lo, hi, n, g;
    logic [2:0] l3;

    // Reset with a write attempt that must be ignored.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'd1;
    repeat (3) @(negedge clk);
    check("rst_led", 64'(led_n), 64'hF);
    check("rst_tick", 64'(tick), 64'd0);
    rst = 1'b0; cfg_we = 1'b0;

    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (tick === 1'b1) n++;
    end
    check("tick_count", 64'(n), 64'd4);

    // Out-of-range channel on the 3-channel instance.
    l3 = led_n3;
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'd1; cfg_period = '0;
    @(negedge clk);
    cfg_we = 1'b0;
    check("err3_pulse", 64'(err3), 64'd1);
    check("err3_led", 64'(led_n3), 64'(l3));
    @(negedge clk);
    check("err3_clear", 64'(err3), 64'd0);
    check("err3_led2", 64'(led_n3), 64'(l3));
    wr(2'd3, 2'd0, '0, '0);

    wr(2'd0, 2'd2, 4'd1, 4'd0);
    pulse(0, lo, hi);
    check("blink_lo", 64'(lo), 64'd8);
    check("blink_hi", 64'(hi), 64'd8);
    check("blink_others", 64'(led_n[3:1]), 64'h7);

`ifdef MULTI_BLINK_PWM_EN
    wr(2'd1, 2'd3, 4'd3, 4'd1);
    pulse(1, lo, hi);
    check("pwm_d1_lo", 64'(lo), 64'd4);
    check("pwm_d1_hi", 64'(hi), 64'd12);
    wr(2'd1, 2'd3, 4'd3, 4'd0);
    hold(1, 1'b1, "pwm_d0");
    wr(2'd1, 2'd3, 4'd3, 4'd5);
    hold(1, 1'b0, "pwm_d5");
`else
    wr(2'd1, 2'd3, 4'd1, 4'd1);
    pulse(1, lo, hi);
    check("mode3_lo", 64'(lo), 64'd8);
    check("mode3_hi", 64'(hi), 64'd8);
`endif
    wr(2'd1, 2'd0, '0, '0);

    // Collision: ch0 rewritten on an edge that samples tick=1.
    wr(2'd2, 2'd2, 4'd0, 4'd0);
    g = 0;
    while (tick !== 1'b1 && g < 10) begin @(negedge clk); g++; end
    check("coll_sync", 64'(tick), 64'd1);
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'd2; cfg_period = 4'd2; cfg_duty = '0;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    check("coll_b0", 64'(led_n[0]), 64'd1);
    pulse(0, lo, hi);
    check("coll_lo", 64'(lo), 64'd12);
    check("coll_hi", 64'(hi), 64'd12);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst", 64'(led_n), 64'hF);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_blink.md
# multi_blink

Multi-channel LED pattern generator, the parametrised successor of the single-channel blinker. A shared prescaler derives a slow tick from the system clock. Each of NUM_CH channels independently runs OFF, ON, BLINK or PWM with a runtime-programmable period and duty. The block sits between the board top-level (active-low LED pins) and whatever control logic writes channel configurations.

## Interface
- NUM_CH, 12: number of LED channels, 1..64
- PRESC_DIV, 50000: system clocks per tick, at least 2; prescaler width is $clog2(PRESC_DIV)
- PER_W, 8: width of the period, duty and phase counters
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  configuration write strobe, one write per cycle it is high
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel index
- cfg_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 PWM
- cfg_period  in  PER_W  phase wrap value P; cycle is P+1 ticks
- cfg_duty  in  PER_W  PWM on-ticks D
- tick  out  1  registered one-cycle prescaler pulse
- cfg_err  out  1  registered one-cycle pulse: write to cfg_ch >= NUM_CH
- led_n  out  NUM_CH  registered LED drive, active-low (0 = lit)

## Operation
- Prescaler counts 0..PRESC_DIV-1 and wraps. The cycle after it holds PRESC_DIV-1, tick is 1; otherwise tick is 0. Tick period is exactly PRESC_DIV clocks.
- Per-channel state: mode, period P, duty D, phase cnt, blink bit b.
- On each edge where tick=1 is sampled:
  - if cnt == P: cnt <= 0 and b toggles
  - else: cnt <= cnt+1
  - cnt advances in all modes.
- Lit condition:
  - OFF: never
  - ON: always
  - BLINK: b==1, giving a full cycle of 2(P+1) ticks
  - PWM: cnt < D, so D=0 is never lit and D>P is always lit
- led_n[i] is the registered inverse of the lit condition.
- Config write, cfg_we=1 with cfg_ch < NUM_CH:
  - mode, P and D of that channel load at the edge
  - cnt and b clear to 0 at the same edge
  - other channels are untouched.
- cfg_we=1 with cfg_ch >= NUM_CH: no state change; cfg_err=1 for the following cycle.
- Write and tick on the same edge to the same channel: the write wins (cnt=0, b=0, no increment). Other channels advance normally.
- P=0: cnt stays 0 and b toggles every tick.
- No overflow is possible: cnt never exceeds P, which is at most 2^PER_W-1.

## Timing
- Reset (rst sampled high, any cycle including mid-pattern), after the edge:
  - prescaler=0, tick=0, cfg_err=0
  - all channels mode OFF, P=0, D=0, cnt=0, b=0
  - led_n all ones
  - cfg_we is ignored while rst=1.
- First tick after reset release: tick=1 in the PRESC_DIV-th cycle after the first non-reset edge.
- Config latency: cfg_we sampled at edge E; led_n reflects the new config after edge E+1.
- Tick-to-LED latency: a tick sampled at edge E changes led_n after edge E+1.
- cfg_err pulses in the cycle after the offending write.
- No handshake or back-pressure: every cycle accepts a write.

## Configuration
- MULTI_BLINK_PWM_EN defined:
  - PWM mode, the duty comparators and the per-channel D registers are built
  - cfg_duty is used.
- Not defined:
  - no D registers or comparators
  - mode 3 behaves exactly as BLINK
  - cfg_duty is ignored
  - all other behaviour is identical.

## Test plan
Bench parameters: NUM_CH=4, PRESC_DIV=4, PER_W=4, with MULTI_BLINK_PWM_EN defined unless stated.
- Reset: rst high 3 cycles, then low -> led_n=4'b1111 and tick=0 during reset; tick=1 every 4th cycle afterwards; cfg_err=0.
- BLINK: write ch0 mode 2, P=1 -> led_n[0] low for 8 clocks then high for 8 clocks, repeating; led_n[3:1]=3'b111.
- PWM on ch1, P=3:
  - D=1 -> led_n[1] low 4 clocks, high 12 clocks per 16
  - rewrite D=0 -> constant 1
  - rewrite D=5 -> constant 0.
- Invalid channel: cfg_we with cfg_ch=3'd... not applicable at this width; use cfg_ch=2'b11 on a NUM_CH=3 build -> cfg_err=1 for exactly 1 cycle; led_n unchanged.
- Collision and mid-pattern reset:
  - write ch0 (mode 2, P=2) on the tick edge -> ch0 cnt=0 and b=0 after the edge; ch2 advances on the same tick
  - rst asserted mid-blink -> led_n=4'b1111 after the next edge.
- Build without MULTI_BLINK_PWM_EN: ch1 mode 3, P=1, D=1 -> same waveform as BLINK P=1 (8 clocks low, 8 clocks high).
